// File: rtl/rb_commit_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rb_commit_unit_pkg
//  Description : Shared sizing constants, the per-entry field layout and the
//                pointer-increment helper for the reorder buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package rb_commit_unit_pkg;

    localparam int WORD_SIZE = 32;  // datapath width
    localparam int RB_SIZE   = 8;   // number of entries (power of two)
    localparam int RB_INDEX  = 3;   // log2(RB_SIZE)
    localparam int REG_INDEX = 5;   // architectural register index width

    // Fields held by one reorder-buffer entry.
    typedef struct packed {
        logic [REG_INDEX-1:0] dest;
        logic                 is_store;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
    } rb_entry_t;

    // RB_SIZE is a power of two, so the natural overflow gives the wrap.
    function automatic logic [RB_INDEX-1:0] ptr_inc(input logic [RB_INDEX-1:0] p);
        return p + RB_INDEX'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_commit_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rb_commit_unit_if
//  Description : Bundles the issue, CDB, commit and memory-handshake signals
//                of the reorder buffer.
//                master : producer side (issue logic / CDB / memory)
//                slave  : the reorder buffer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface rb_commit_unit_if;
    import rb_commit_unit_pkg::*;

    logic                         flush;
    logic                         issue_valid;
    logic                         issue_is_store;
    logic [REG_INDEX-1:0]         issue_dest;
    logic                         issue_ready;
    logic [RB_INDEX-1:0]          alloc_index;
    logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
    logic                         mem_ready;
    logic [RB_SIZE-1:0]           rb_busy;
    logic [RB_SIZE-1:0]           rb_done;
    logic                         rf_we;
    logic [REG_INDEX-1:0]         rf_addr;
    logic [WORD_SIZE-1:0]         rf_data;
    logic                         mem_we;
    logic [WORD_SIZE-1:0]         mem_addr;
    logic [WORD_SIZE-1:0]         mem_data;
    logic [RB_INDEX-1:0]          commit_index;

    modport master (
        output flush, issue_valid, issue_is_store, issue_dest,
               CDB_data_data, CDB_data_valid, CDB_data_addr, mem_ready,
        input  issue_ready, alloc_index, rb_busy, rb_done,
               rf_we, rf_addr, rf_data, mem_we, mem_addr, mem_data, commit_index
    );

    modport slave (
        input  flush, issue_valid, issue_is_store, issue_dest,
               CDB_data_data, CDB_data_valid, CDB_data_addr, mem_ready,
        output issue_ready, alloc_index, rb_busy, rb_done,
               rf_we, rf_addr, rf_data, mem_we, mem_addr, mem_data, commit_index
    );

endinterface
`default_nettype wire

// File: rtl/rb_commit_unit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : rb_entry
//  Description : One reorder-buffer entry: busy/done flags, entry fields and
//                the rising-edge detect on this entry's CDB valid level.
//  Ports       : clk, reset        clock, async active-high reset
//                flush_i           squash (clears busy/done)
//                alloc_i           allocate this entry (dest/is_store loaded)
//                commit_i          entry retired this cycle (clears busy)
//                cdb_*_i           this entry's slice of the CDB vectors
//                busy_o, done_o    status flags
//                entry_o           stored fields
//  Revision    : 1.0  initial release
// ============================================================================
module rb_entry
    import rb_commit_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 alloc_i,
    input  logic                 commit_i,
    input  logic [REG_INDEX-1:0] dest_i,
    input  logic                 is_store_i,
    input  logic                 cdb_valid_i,
    input  logic [WORD_SIZE-1:0] cdb_data_i,
    input  logic [WORD_SIZE-1:0] cdb_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output rb_entry_t            entry_o
);

    logic      busy_q;
    logic      done_q;
    logic      prev_valid_q;
    rb_entry_t entry_q;
    logic      w_capture;

    // The CDB level may still be high from the previous occupant; only a
    // fresh 0->1 transition while waiting for a result counts.
    assign w_capture = busy_q & ~done_q & cdb_valid_i & ~prev_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            entry_q      <= '0;
        end else begin
            // Tracks the level every cycle, which also covers the load at
            // allocation time.
            prev_valid_q <= cdb_valid_i;
            if (flush_i) begin
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else if (alloc_i) begin
                busy_q           <= 1'b1;
                done_q           <= 1'b0;
                entry_q.dest     <= dest_i;
                entry_q.is_store <= is_store_i;
            end else begin
                if (w_capture) begin
                    done_q       <= 1'b1;
                    entry_q.data <= cdb_data_i;
                    entry_q.addr <= cdb_addr_i;
                end
                if (commit_i) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/rb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rb_commit_unit
//  Description : Reorder buffer with in-order commit. Allocates at the tail,
//                captures results from per-entry CDB vectors, retires one
//                entry per cycle from the head to the register file or memory.
//  Ports       : clk, reset   clock, async active-high reset
//                bus          rb_commit_unit_if.slave (issue, CDB, commit,
//                             memory handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module rb_commit_unit
    import rb_commit_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    rb_commit_unit_if.slave     bus
);

    logic [RB_INDEX-1:0]  head_q, head_d;
    logic [RB_INDEX-1:0]  tail_q, tail_d;
    logic [RB_INDEX:0]    count_q, count_d;

    logic [RB_SIZE-1:0]   w_busy, w_done, w_alloc, w_commit;
    rb_entry_t            w_entry [RB_SIZE];
    rb_entry_t            w_head;
    logic                 w_issue_ready, w_do_alloc, w_do_commit;

    logic                 rf_we_q, mem_we_q;
    logic [REG_INDEX-1:0] rf_addr_q;
    logic [WORD_SIZE-1:0] rf_data_q, mem_addr_q, mem_data_q;
    logic [RB_INDEX-1:0]  commit_index_q;

    assign w_issue_ready = (count_q != (RB_INDEX+1)'(RB_SIZE));
    assign w_head        = w_entry[head_q];

    // Flush wins over everything issued or retired in the same cycle.
    assign w_do_alloc  = bus.issue_valid & w_issue_ready & ~bus.flush;
    assign w_do_commit = ~bus.flush & w_busy[head_q] & w_done[head_q]
                       & (~w_head.is_store | bus.mem_ready);

    generate
        for (genvar i = 0; i < RB_SIZE; i++) begin : g_entry
            assign w_alloc[i]  = w_do_alloc  & (tail_q == RB_INDEX'(i));
            assign w_commit[i] = w_do_commit & (head_q == RB_INDEX'(i));

            rb_entry u_entry (
                .clk         (clk),
                .reset       (reset),
                .flush_i     (bus.flush),
                .alloc_i     (w_alloc[i]),
                .commit_i    (w_commit[i]),
                .dest_i      (bus.issue_dest),
                .is_store_i  (bus.issue_is_store),
                .cdb_valid_i (bus.CDB_data_valid[i]),
                .cdb_data_i  (bus.CDB_data_data[i*WORD_SIZE +: WORD_SIZE]),
                .cdb_addr_i  (bus.CDB_data_addr[i*WORD_SIZE +: WORD_SIZE]),
                .busy_o      (w_busy[i]),
                .done_o      (w_done[i]),
                .entry_o     (w_entry[i])
            );
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_do_alloc)  tail_d = ptr_inc(tail_q);
            if (w_do_commit) head_d = ptr_inc(head_q);
            case ({w_do_alloc, w_do_commit})
                2'b10:   count_d = count_q + (RB_INDEX+1)'(1);
                2'b01:   count_d = count_q - (RB_INDEX+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            rf_we_q        <= 1'b0;
            rf_addr_q      <= '0;
            rf_data_q      <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            commit_index_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            // Strobes are single-cycle; the data fields hold their last value.
            rf_we_q  <= w_do_commit & ~w_head.is_store;
            mem_we_q <= w_do_commit &  w_head.is_store;
            if (w_do_commit) begin
                commit_index_q <= head_q;
                if (w_head.is_store) begin
                    mem_addr_q <= w_head.addr;
                    mem_data_q <= w_head.data;
                end else begin
                    rf_addr_q  <= w_head.dest;
                    rf_data_q  <= w_head.data;
                end
            end
        end
    end

    assign bus.issue_ready  = w_issue_ready;
    assign bus.alloc_index  = tail_q;
    assign bus.rb_busy      = w_busy;
    assign bus.rb_done      = w_done;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_addr      = rf_addr_q;
    assign bus.rf_data      = rf_data_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.commit_index = commit_index_q;

endmodule
`default_nettype wire

// File: tb/tb_rb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rb_commit_unit
//  Description : Directed self-checking bench for rb_commit_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rb_commit_unit;
    import rb_commit_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rb_commit_unit_if u_if ();

    rb_commit_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cdb(input int i, input logic v, input logic [31:0] d, input logic [31:0] a);
        u_if.CDB_data_valid[i]          = v;
        u_if.CDB_data_data[i*32 +: 32]  = d;
        u_if.CDB_data_addr[i*32 +: 32]  = a;
    endtask

    task automatic clear_inputs;
        u_if.flush          = 1'b0;
        u_if.issue_valid    = 1'b0;
        u_if.issue_is_store = 1'b0;
        u_if.issue_dest     = '0;
        u_if.CDB_data_data  = '0;
        u_if.CDB_data_valid = '0;
        u_if.CDB_data_addr  = '0;
        u_if.mem_ready      = 1'b1;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_issue_ready", 32'(u_if.issue_ready), 32'd1);
        chk("rst_busy",        32'(u_if.rb_busy),     32'd0);
        chk("rst_rf_we",       32'(u_if.rf_we),       32'd0);
        chk("rst_mem_we",      32'(u_if.mem_we),      32'd0);
        chk("rst_alloc_index", 32'(u_if.alloc_index), 32'd0);
        chk("rst_rf_data",     u_if.rf_data,          32'd0);

        // ---------------- stale valid ----------------
        set_cdb(0, 1'b1, 32'hDEAD, 32'h0);
        tick();
        u_if.issue_valid = 1'b1;
        u_if.issue_dest  = 5'd5;
        tick();
        u_if.issue_valid = 1'b0;
        chk("stale_busy",  32'(u_if.rb_busy),     32'h01);
        chk("stale_alloc", 32'(u_if.alloc_index), 32'd1);
        chk("stale_done0", 32'(u_if.rb_done),     32'h00);
        tick();
        chk("stale_done1", 32'(u_if.rb_done),     32'h00);
        set_cdb(0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("stale_done2", 32'(u_if.rb_done),     32'h00);
        set_cdb(0, 1'b1, 32'h1234, 32'h0);
        tick();
        chk("edge_done",   32'(u_if.rb_done),     32'h01);
        chk("edge_rf_we0", 32'(u_if.rf_we),       32'd0);
        tick();
        chk("edge_rf_we1", 32'(u_if.rf_we),       32'd1);
        chk("edge_rf_data", u_if.rf_data,         32'h1234);
        chk("edge_rf_addr", 32'(u_if.rf_addr),    32'd5);
        chk("edge_busy",   32'(u_if.rb_busy),     32'h00);
        tick();
        chk("edge_rf_we2", 32'(u_if.rf_we),       32'd0);
        chk("edge_hold",   u_if.rf_data,          32'h1234);

        // ---------------- out-of-order completion ----------------
        do_reset();
        u_if.issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.issue_dest = 5'(i + 1);
            tick();
        end
        u_if.issue_valid = 1'b0;
        chk("ooo_busy",  32'(u_if.rb_busy),     32'h07);
        chk("ooo_alloc", 32'(u_if.alloc_index), 32'd3);
        set_cdb(2, 1'b1, 32'hA2, 32'h0);
        tick();
        chk("ooo_done2", 32'(u_if.rb_done), 32'h04);
        chk("ooo_nocommit", 32'(u_if.rf_we), 32'd0);
        set_cdb(0, 1'b1, 32'hA0, 32'h0);
        tick();
        chk("ooo_done0", 32'(u_if.rb_done), 32'h05);
        chk("ooo_nocommit2", 32'(u_if.rf_we), 32'd0);
        set_cdb(1, 1'b1, 32'hA1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ooo_we",   32'(u_if.rf_we),        32'd1);
            chk("ooo_idx",  32'(u_if.commit_index), 32'(i));
            chk("ooo_data", u_if.rf_data,           32'hA0 + 32'(i));
            chk("ooo_addr", 32'(u_if.rf_addr),      32'(i + 1));
        end
        tick();
        chk("ooo_we_end",   32'(u_if.rf_we),   32'd0);
        chk("ooo_busy_end", 32'(u_if.rb_busy), 32'h00);

        // ---------------- full and wrap ----------------
        do_reset();
        u_if.issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            u_if.issue_dest = 5'(i + 8);
            tick();
        end
        u_if.issue_dest = 5'd20;
        chk("full_ready", 32'(u_if.issue_ready), 32'd0);
        chk("full_busy",  32'(u_if.rb_busy),     32'hFF);
        chk("full_alloc", 32'(u_if.alloc_index), 32'd0);
        set_cdb(0, 1'b1, 32'hC0, 32'h0);
        tick();
        chk("full_done",   32'(u_if.rb_done),     32'h01);
        chk("full_ready2", 32'(u_if.issue_ready), 32'd0);
        tick();
        chk("full_commit", 32'(u_if.rf_we),       32'd1);
        chk("full_cidx",   32'(u_if.commit_index), 32'd0);
        chk("full_cdata",  u_if.rf_data,          32'hC0);
        chk("full_busy2",  32'(u_if.rb_busy),     32'hFE);
        chk("full_ready3", 32'(u_if.issue_ready), 32'd1);
        chk("full_alloc2", 32'(u_if.alloc_index), 32'd0);
        tick();
        u_if.issue_valid = 1'b0;
        chk("wrap_busy",  32'(u_if.rb_busy),     32'hFF);
        chk("wrap_alloc", 32'(u_if.alloc_index), 32'd1);
        chk("wrap_ready", 32'(u_if.issue_ready), 32'd0);
        chk("wrap_done",  32'(u_if.rb_done),     32'h00);
        chk("wrap_rf_we", 32'(u_if.rf_we),       32'd0);

        // ---------------- store stall ----------------
        do_reset();
        u_if.issue_valid    = 1'b1;
        u_if.issue_is_store = 1'b1;
        tick();
        u_if.issue_valid    = 1'b0;
        u_if.issue_is_store = 1'b0;
        u_if.mem_ready      = 1'b0;
        set_cdb(0, 1'b1, 32'hBEEF, 32'h40);
        tick();
        chk("st_done", 32'(u_if.rb_done), 32'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_stall_we",   32'(u_if.mem_we),  32'd0);
            chk("st_stall_busy", 32'(u_if.rb_busy), 32'h01);
        end
        u_if.mem_ready = 1'b1;
        tick();
        chk("st_we",    32'(u_if.mem_we),  32'd1);
        chk("st_addr",  u_if.mem_addr,     32'h40);
        chk("st_data",  u_if.mem_data,     32'hBEEF);
        chk("st_rf_we", 32'(u_if.rf_we),   32'd0);
        chk("st_busy",  32'(u_if.rb_busy), 32'h00);
        tick();
        chk("st_we_end",  32'(u_if.mem_we), 32'd0);
        chk("st_hold",    u_if.mem_addr,    32'h40);

        // ---------------- flush ----------------
        do_reset();
        u_if.issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.issue_dest = 5'(i + 1);
            tick();
        end
        u_if.issue_valid = 1'b0;
        set_cdb(0, 1'b1, 32'h66, 32'h0);
        tick();
        chk("fl_done", 32'(u_if.rb_done), 32'h01);
        u_if.flush = 1'b1;
        tick();
        u_if.flush = 1'b0;
        chk("fl_rf_we", 32'(u_if.rf_we),       32'd0);
        chk("fl_busy",  32'(u_if.rb_busy),     32'h00);
        chk("fl_done2", 32'(u_if.rb_done),     32'h00);
        chk("fl_ready", 32'(u_if.issue_ready), 32'd1);
        chk("fl_alloc", 32'(u_if.alloc_index), 32'd0);
        chk("fl_data",  u_if.rf_data,          32'd0);
        u_if.issue_valid = 1'b1;
        u_if.issue_dest  = 5'd7;
        tick();
        u_if.issue_valid = 1'b0;
        chk("fl_busy2",  32'(u_if.rb_busy),     32'h01);
        chk("fl_alloc2", 32'(u_if.alloc_index), 32'd1);
        tick();
        chk("fl_stale",  32'(u_if.rb_done), 32'h00);
        chk("fl_rf_we2", 32'(u_if.rf_we),   32'd0);

        // ---------------- reset mid-operation ----------------
        do_reset();
        u_if.issue_valid = 1'b1;
        u_if.issue_dest  = 5'd3;
        tick();
        u_if.issue_valid = 1'b0;
        set_cdb(0, 1'b1, 32'h77, 32'h0);
        tick();
        tick();
        chk("mr_we_pre", 32'(u_if.rf_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_we",   32'(u_if.rf_we),   32'd0);
        chk("mr_busy", 32'(u_if.rb_busy), 32'h00);
        chk("mr_data", u_if.rf_data,      32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
